// File: rtl/credit_ledger.sv
// Credit store: accepts coins, grants or denies purchases,
// and pays remaining credit out as a stream of change coins.
module credit_ledger #(
   parameter int WIDTH    = 8,
   parameter int BIG_COIN = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             coin_valid,
   input  logic [WIDTH-1:0] coin_value,
   output logic             coin_ready,
   output logic             coin_reject,
   input  logic             buy_req,
   input  logic [WIDTH-1:0] buy_price,
   output logic             vend,
   output logic             buy_deny,
   input  logic             refund_req,
   output logic             change_valid,
   output logic             change_big,
   input  logic             change_ack,
   output logic             refund_done,
   output logic [WIDTH-1:0] credit
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] PAYOUT = 1'b1;

   localparam logic [WIDTH-1:0] BIG = WIDTH'(BIG_COIN);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [0:0]       state;
   logic             payout;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] step_w;
   logic [WIDTH-1:0] left_w;

   assign payout       = (state == PAYOUT);
   assign coin_ready   = ~payout & ~buy_req;
   assign change_valid = payout;
   assign change_big   = payout & (credit >= BIG);

   // adder stage result: carry in sum_w[WIDTH] means overflow
   assign sum_w  = {1'b0, credit} + {1'b0, coin_value};
   assign step_w = change_big ? BIG : ONE;
   assign left_w = credit - step_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         credit      <= '0;
         vend        <= 1'b0;
         buy_deny    <= 1'b0;
         coin_reject <= 1'b0;
         refund_done <= 1'b0;
      end else begin
         vend        <= 1'b0;
         buy_deny    <= 1'b0;
         coin_reject <= 1'b0;
         refund_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (buy_req) begin
                  if (buy_price <= credit) begin
                     credit <= credit - buy_price;
                     vend   <= 1'b1;
                  end else begin
                     buy_deny <= 1'b1;
                  end
               end else if (refund_req) begin
                  if (credit == '0) refund_done <= 1'b1;
                  else state <= PAYOUT;
               end else if (coin_valid) begin
                  if (sum_w[WIDTH]) coin_reject <= 1'b1;
                  else credit <= sum_w[WIDTH-1:0];
               end
            end
            PAYOUT: begin
               if (buy_req) buy_deny <= 1'b1;
               if (change_ack) begin
                  credit <= left_w;
                  if (left_w == '0) begin
                     state       <= IDLE;
                     refund_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_credit_ledger.sv
// Randomized bench for credit_ledger against a plain
// arithmetic model of credit, purchases and payout.
module tb_credit_ledger;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       coin_ready;
   logic       coin_reject;
   logic       buy_req;
   logic [7:0] buy_price;
   logic       vend;
   logic       buy_deny;
   logic       refund_req;
   logic       change_valid;
   logic       change_big;
   logic       change_ack;
   logic       refund_done;
   logic [7:0] credit;

   int total = 0;
   int bad   = 0;

   int m_cr;
   bit m_pay;
   bit e_vend, e_deny, e_rej, e_done;

   bit bigs[$];

   credit_ledger #(.WIDTH(8), .BIG_COIN(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .coin_ready   (coin_ready),
      .coin_reject  (coin_reject),
      .buy_req      (buy_req),
      .buy_price    (buy_price),
      .vend         (vend),
      .buy_deny     (buy_deny),
      .refund_req   (refund_req),
      .change_valid (change_valid),
      .change_big   (change_big),
      .change_ack   (change_ack),
      .refund_done  (refund_done),
      .credit       (credit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cr   = 0;
      m_pay  = 0;
      e_vend = 0;
      e_deny = 0;
      e_rej  = 0;
      e_done = 0;
   endtask

   // one clock of the reference rules; returns whether a coin was taken
   task automatic model_step(output bit acc);
      acc    = coin_valid && !m_pay && !buy_req;
      e_vend = 0;
      e_deny = 0;
      e_rej  = 0;
      e_done = 0;
      if (!m_pay) begin
         if (buy_req) begin
            if (int'(buy_price) <= m_cr) begin
               m_cr   = m_cr - int'(buy_price);
               e_vend = 1;
            end else e_deny = 1;
         end else if (refund_req) begin
            if (m_cr == 0) e_done = 1;
            else m_pay = 1;
         end else if (coin_valid) begin
            if (m_cr + int'(coin_value) > 255) e_rej = 1;
            else m_cr = m_cr + int'(coin_value);
         end
      end else begin
         if (buy_req) e_deny = 1;
         if (change_ack) begin
            m_cr = m_cr - ((m_cr >= 5) ? 5 : 1);
            if (m_cr == 0) begin
               m_pay  = 0;
               e_done = 1;
            end
         end
      end
   endtask

   // called at negedge with inputs driven; returns at next negedge
   task automatic cyc();
      bit acc;
      #1;
      chk("ready", coin_ready, int'(!m_pay && !buy_req));
      chk("cvalid_pre", change_valid, m_pay);
      chk("cbig_pre", change_big, int'(m_pay && m_cr >= 5));
      chk("credit_pre", credit, m_cr);
      @(posedge clk);
      model_step(acc);
      #1;
      chk("vend", vend, e_vend);
      chk("deny", buy_deny, e_deny);
      chk("reject", coin_reject, e_rej);
      chk("done", refund_done, e_done);
      chk("credit", credit, m_cr);
      chk("cvalid", change_valid, m_pay);
      @(negedge clk);
      buy_req    = 0;
      refund_req = 0;
      change_ack = 0;
      if (acc) coin_valid = 0;
   endtask

   task automatic coin(input int v);
      coin_valid = 1;
      coin_value = 8'(v);
      for (int i = 0; i < 5 && coin_valid; i++) cyc();
      chk("coin_timeout", coin_valid, 0);
   endtask

   task automatic buy(input int p);
      buy_req   = 1;
      buy_price = 8'(p);
      cyc();
   endtask

   // drains payout with 0-3 idle cycles before each ack
   task automatic drain(input bit req);
      int n;
      bigs.delete();
      if (req) begin
         refund_req = 1;
         cyc();
      end
      n = 0;
      while (change_valid && n < 1200) begin
         repeat ($urandom_range(0, 3)) begin
            cyc();
            n++;
         end
         bigs.push_back(change_big);
         change_ack = 1;
         cyc();
         n++;
      end
      chk("drain_timeout", change_valid, 0);
      chk("drain_done", refund_done, 1);
      chk("drain_credit", credit, 0);
   endtask

   initial begin
      rst_n      = 0;
      coin_valid = 0;
      coin_value = 0;
      buy_req    = 0;
      buy_price  = 0;
      refund_req = 0;
      change_ack = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_credit", credit, 0);
      chk("rst_cvalid", change_valid, 0);
      chk("rst_cbig", change_big, 0);
      chk("rst_vend", vend, 0);
      chk("rst_deny", buy_deny, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_done", refund_done, 0);
      chk("rst_ready", coin_ready, 1);
      rst_n = 1;

      coin(5);
      coin(3);
      chk("acc8", credit, 8);
      buy(6);
      chk("vend6", vend, 1);
      chk("cred2", credit, 2);
      buy(3);
      chk("deny3", buy_deny, 1);
      chk("cred2b", credit, 2);
      drain(1);

      refund_req = 1;
      cyc();
      chk("done_zero", refund_done, 1);
      chk("no_cvalid", change_valid, 0);

      coin(250);
      coin(10);
      chk("ovf_rej", coin_reject, 1);
      chk("ovf_cred", credit, 250);
      coin(5);
      chk("max_rej", coin_reject, 0);
      chk("max_cred", credit, 255);
      drain(1);

      coin(12);
      drain(1);
      chk("pay_cnt", bigs.size(), 4);
      if (bigs.size() == 4) begin
         chk("pay_c0", bigs[0], 1);
         chk("pay_c1", bigs[1], 1);
         chk("pay_c2", bigs[2], 0);
         chk("pay_c3", bigs[3], 0);
      end

      coin(10);
      buy_req    = 1;
      buy_price  = 10;
      coin_valid = 1;
      coin_value = 5;
      cyc();
      chk("col_vend", vend, 1);
      chk("col_wait", coin_valid, 1);
      cyc();
      chk("col_cred", credit, 5);

      refund_req = 1;
      cyc();
      buy(0);
      chk("pay_deny", buy_deny, 1);
      chk("pay_cred", credit, 5);
      drain(0);

      coin(7);
      refund_req = 1;
      cyc();
      chk("pre_rst_cv", change_valid, 1);
      chk("pre_rst_cr", credit, 7);
      #2 rst_n = 0;
      #1;
      chk("arst_cv", change_valid, 0);
      chk("arst_cr", credit, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      coin(3);
      chk("post_rst", credit, 3);

      for (int i = 0; i < 3000; i++) begin
         if (!coin_valid && $urandom_range(0, 3) == 0) begin
            coin_valid = 1;
            coin_value = ($urandom_range(0, 7) == 0) ?
                         8'($urandom_range(0, 255)) :
                         8'($urandom_range(1, 20));
         end
         buy_req    = ($urandom_range(0, 5) == 0);
         buy_price  = 8'($urandom_range(0, 40));
         refund_req = !coin_valid && ($urandom_range(0, 24) == 0);
         change_ack = $urandom_range(0, 1) == 1;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
